axi_mgr_split: RTL and testbench

Manager-side splitter that takes one unified request stream (dv/addr/write/wdata/wstrb/last with hld back-pressure) and routes each burst to a read-manager engine or a write-manager engine. It is the inverse of the subordinate read/write arbiter, feeding the AXI manager engines (AR/R and AW/W/B) from a single native initiator. It locks direction for the length of a burst and tracks outstanding write bursts. It optionally holds reads behind in-flight writes for read-after-write ordering.

---
 rtl/axi_pkg.sv | 10 +
 rtl/axi_mgr_split_if.sv | 65 ++++++
 rtl/axi_out_ctr.sv | 39 +++
 rtl/axi_mgr_split.sv | 113 +++++++++++
 tb/tb_axi_mgr_split.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared types for the manager-side read/write splitter.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } axi_mgr_split_state_e;

endpackage

// File: rtl/axi_mgr_split_if.sv
// Unified request bus plus read/write engine connections for axi_mgr_split.
// slave = the splitter's view; master = the initiator/engine environment.
interface axi_mgr_split_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1
);
    localparam int BC = DW / 8;

    logic          dv;
    logic [AW-1:0] addr;
    logic          write;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
    logic [DW-1:0] wdata;
    logic [BC-1:0] wstrb;
    logic          last;
    logic          hld;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rd_err;
    logic          wr_done;
    logic          wr_err;

    logic          r_dv;
    logic [AW-1:0] r_addr;
    logic [UW-1:0] r_user;
    logic [IW-1:0] r_id;
    logic          r_last;
    logic          r_hld;
    logic [DW-1:0] r_rdata;
    logic          r_rvalid;
    logic          r_err;

    logic          w_dv;
    logic [AW-1:0] w_addr;
    logic [UW-1:0] w_user;
    logic [IW-1:0] w_id;
    logic [DW-1:0] w_wdata;
    logic [BC-1:0] w_wstrb;
    logic          w_last;
    logic          w_hld;
    logic          w_resp_valid;
    logic          w_resp_err;

    modport slave (
        input  dv, addr, write, user, id, wdata, wstrb, last,
        output hld, rdata, rvalid, rd_err, wr_done, wr_err,
        output r_dv, r_addr, r_user, r_id, r_last,
        input  r_hld, r_rdata, r_rvalid, r_err,
        output w_dv, w_addr, w_user, w_id, w_wdata, w_wstrb, w_last,
        input  w_hld, w_resp_valid, w_resp_err
    );

    modport master (
        output dv, addr, write, user, id, wdata, wstrb, last,
        input  hld, rdata, rvalid, rd_err, wr_done, wr_err,
        input  r_dv, r_addr, r_user, r_id, r_last,
        output r_hld, r_rdata, r_rvalid, r_err,
        input  w_dv, w_addr, w_user, w_id, w_wdata, w_wstrb, w_last,
        output w_hld, w_resp_valid, w_resp_err
    );

endinterface

// File: rtl/axi_out_ctr.sv
// Saturating up/down counter of outstanding bursts; simultaneous inc/dec cancel.
module axi_out_ctr #(
    parameter  int MAX_OUT = 4,
    localparam int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign full  = (count_q == CW'(MAX_OUT));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_mgr_split.sv
// Routes a unified request stream to read/write manager engines, locking direction per burst.
// Define AXI_MGR_SPLIT_RAW_ORDER_EN to hold read starts while any write burst is outstanding.
module axi_mgr_split
    import axi_pkg::*;
#(
    parameter  int MAX_OUT = 4,
    localparam int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_mgr_split_if.slave    bus
);

    axi_mgr_split_state_e state_q;
    axi_mgr_split_state_e state_d;

    logic [CW-1:0] wcnt;
    logic          ctr_full;
    logic          ctr_empty;
    logic          in_idle;
    logic          rd_sel;
    logic          wr_sel;
    logic          mismatch;
    logic          rd_blk;
    logic          blk;
    logic          accept;
    logic          wr_start;

    assign in_idle  = (state_q == IDLE);
    assign rd_sel   = (state_q != WR_BURST);
    assign wr_sel   = (state_q != RD_BURST);
    assign mismatch = bus.dv && (((state_q == RD_BURST) && bus.write) ||
                                 ((state_q == WR_BURST) && !bus.write));

`ifdef AXI_MGR_SPLIT_RAW_ORDER_EN
    assign rd_blk = !ctr_empty;
`else
    assign rd_blk = 1'b0;
`endif

    // Blocking only gates burst starts; a burst in progress always completes.
    assign blk      = in_idle && bus.dv && (bus.write ? ctr_full : rd_blk);
    assign bus.hld  = blk || mismatch || (bus.write ? bus.w_hld : bus.r_hld);
    assign accept   = bus.dv && !bus.hld;
    assign wr_start = accept && bus.write && in_idle;

    assign bus.r_dv    = rst_n && bus.dv && !bus.write && rd_sel && !blk;
    assign bus.r_addr  = bus.addr;
    assign bus.r_user  = bus.user;
    assign bus.r_id    = bus.id;
    assign bus.r_last  = bus.last;

    assign bus.w_dv    = rst_n && bus.dv && bus.write && wr_sel && !blk;
    assign bus.w_addr  = bus.addr;
    assign bus.w_user  = bus.user;
    assign bus.w_id    = bus.id;
    assign bus.w_wdata = bus.wdata;
    assign bus.w_wstrb = bus.wstrb;
    assign bus.w_last  = bus.last;

    assign bus.rdata   = bus.r_rdata;
    assign bus.rvalid  = bus.r_rvalid;
    assign bus.rd_err  = bus.r_err;
    assign bus.wr_done = bus.w_resp_valid;
    assign bus.wr_err  = bus.w_resp_err;

    axi_out_ctr #(
        .MAX_OUT (MAX_OUT)
    ) u_out_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_start),
        .dec   (bus.w_resp_valid),
        .count (wcnt),
        .full  (ctr_full),
        .empty (ctr_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !bus.last) begin
                    state_d = bus.write ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (accept && bus.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifndef SYNTHESIS
    AXI_MGR_SPLIT_DIR_MISMATCH: assert property (@(posedge clk) disable iff (!rst_n) !mismatch)
        else $warning("AXI_MGR_SPLIT_DIR_MISMATCH: beat direction disagrees with locked burst");

    AXI_MGR_SPLIT_UNDERFLOW: assert property (@(posedge clk) disable iff (!rst_n)
                                              !(bus.w_resp_valid && ctr_empty))
        else $error("AXI_MGR_SPLIT_UNDERFLOW: write response with no outstanding burst");
`endif

endmodule

// File: tb/tb_axi_mgr_split.sv
// Directed bench for axi_mgr_split with a queue scoreboard for forwarded beats and read data.
module tb_axi_mgr_split;
    import axi_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    beat_t       w_exp[$];
    beat_t       r_exp[$];
    logic [31:0] rdata_exp[$];

    axi_mgr_split_if #(.AW(32), .DW(32), .UW(32), .IW(1)) bus ();

    axi_mgr_split #(.MAX_OUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        bus.dv           = 1'b0;
        bus.write        = 1'b0;
        bus.addr         = '0;
        bus.user         = '0;
        bus.id           = '0;
        bus.wdata        = '0;
        bus.wstrb        = '0;
        bus.last         = 1'b0;
        bus.r_hld        = 1'b0;
        bus.r_rdata      = '0;
        bus.r_rvalid     = 1'b0;
        bus.r_err        = 1'b0;
        bus.w_hld        = 1'b0;
        bus.w_resp_valid = 1'b0;
        bus.w_resp_err   = 1'b0;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic lst);
        bus.dv    = 1'b1;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = '1;
        bus.last  = lst;
    endtask

    task automatic pushW(input logic [31:0] a, input logic [31:0] d, input logic lst);
        beat_t b;
        b.addr = a;
        b.data = d;
        b.last = lst;
        w_exp.push_back(b);
    endtask

    task automatic pushR(input logic [31:0] a, input logic lst);
        beat_t b;
        b.addr = a;
        b.data = '0;
        b.last = lst;
        r_exp.push_back(b);
    endtask

    task automatic scoreboardPop();
        beat_t e;
        logic [31:0] d;
        if (bus.w_dv && !bus.w_hld) begin
            checkOutput("w_sb_has_entry", 64'(w_exp.size() != 0), 64'd1);
            if (w_exp.size() != 0) begin
                e = w_exp.pop_front();
                checkOutput("w_addr", 64'(bus.w_addr), 64'(e.addr));
                checkOutput("w_wdata", 64'(bus.w_wdata), 64'(e.data));
                checkOutput("w_last", 64'(bus.w_last), 64'(e.last));
            end
        end
        if (bus.r_dv && !bus.r_hld) begin
            checkOutput("r_sb_has_entry", 64'(r_exp.size() != 0), 64'd1);
            if (r_exp.size() != 0) begin
                e = r_exp.pop_front();
                checkOutput("r_addr", 64'(bus.r_addr), 64'(e.addr));
                checkOutput("r_last", 64'(bus.r_last), 64'(e.last));
            end
        end
        if (bus.rvalid) begin
            checkOutput("rdata_sb_has_entry", 64'(rdata_exp.size() != 0), 64'd1);
            if (rdata_exp.size() != 0) begin
                d = rdata_exp.pop_front();
                checkOutput("rdata", 64'(bus.rdata), 64'(d));
            end
        end
    endtask

    task automatic sampleNeg();
        @(negedge clk);
        scoreboardPop();
    endtask

    task automatic toPos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idleInputs();
        rst_n = 1'b0;

        // Reset: request presented but nothing may be forwarded.
        bus.dv = 1'b1;
        sampleNeg();
        checkOutput("rst_r_dv_forced", 64'(bus.r_dv), 64'd0);
        checkOutput("rst_w_dv", 64'(bus.w_dv), 64'd0);
        checkOutput("rst_state", 64'(dut.state_q), 64'(IDLE));
        checkOutput("rst_wcnt", 64'(dut.wcnt), 64'd0);
        bus.dv = 1'b0;
        sampleNeg();
        checkOutput("rst_hld", 64'(bus.hld), 64'd0);
        checkOutput("rst_rvalid", 64'(bus.rvalid), 64'd0);
        checkOutput("rst_wr_done", 64'(bus.wr_done), 64'd0);
        toPos();
        rst_n = 1'b1;
        toPos();

        // Single-beat read with same-cycle data return.
        applyStimulus(1'b0, 32'h100, 32'h0, 1'b1);
        bus.r_rvalid = 1'b1;
        bus.r_rdata  = 32'hDEADBEEF;
        pushR(32'h100, 1'b1);
        rdata_exp.push_back(32'hDEADBEEF);
        sampleNeg();
        checkOutput("rd1_r_dv", 64'(bus.r_dv), 64'd1);
        checkOutput("rd1_w_dv", 64'(bus.w_dv), 64'd0);
        checkOutput("rd1_hld", 64'(bus.hld), 64'd0);
        toPos();
        idleInputs();
        checkOutput("rd1_state", 64'(dut.state_q), 64'(IDLE));

        // Four-beat write burst with a three-cycle engine stall on beat 2.
        applyStimulus(1'b1, 32'h200, 32'hA0, 1'b0);
        pushW(32'h200, 32'hA0, 1'b0);
        sampleNeg();
        checkOutput("wb_b1_w_dv", 64'(bus.w_dv), 64'd1);
        checkOutput("wb_b1_hld", 64'(bus.hld), 64'd0);
        toPos();
        checkOutput("wb_state_burst", 64'(dut.state_q), 64'(WR_BURST));
        checkOutput("wb_wcnt_1", 64'(dut.wcnt), 64'd1);
        applyStimulus(1'b1, 32'h204, 32'hA1, 1'b0);
        pushW(32'h204, 32'hA1, 1'b0);
        bus.w_hld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sampleNeg();
            checkOutput("wb_stall_hld", 64'(bus.hld), 64'd1);
            toPos();
            checkOutput("wb_stall_state", 64'(dut.state_q), 64'(WR_BURST));
        end
        bus.w_hld = 1'b0;
        sampleNeg();
        checkOutput("wb_b2_hld", 64'(bus.hld), 64'd0);
        toPos();
        applyStimulus(1'b1, 32'h208, 32'hA2, 1'b0);
        pushW(32'h208, 32'hA2, 1'b0);
        sampleNeg();
        toPos();
        applyStimulus(1'b1, 32'h20C, 32'hA3, 1'b1);
        pushW(32'h20C, 32'hA3, 1'b1);
        sampleNeg();
        toPos();
        idleInputs();
        checkOutput("wb_state_idle", 64'(dut.state_q), 64'(IDLE));
        checkOutput("wb_wcnt_still_1", 64'(dut.wcnt), 64'd1);
        bus.w_resp_valid = 1'b1;
        sampleNeg();
        checkOutput("wb_wr_done", 64'(bus.wr_done), 64'd1);
        toPos();
        idleInputs();
        checkOutput("wb_wcnt_0", 64'(dut.wcnt), 64'd0);

        // Fill to MAX_OUT, then one response releases the fifth write start.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
            pushW(32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
            sampleNeg();
            checkOutput("fill_hld", 64'(bus.hld), 64'd0);
            toPos();
            checkOutput("fill_wcnt", 64'(dut.wcnt), 64'(i + 1));
        end
        applyStimulus(1'b1, 32'h310, 32'hB4, 1'b1);
        sampleNeg();
        checkOutput("full_hld", 64'(bus.hld), 64'd1);
        checkOutput("full_w_dv", 64'(bus.w_dv), 64'd0);
        toPos();
        checkOutput("full_wcnt", 64'(dut.wcnt), 64'd4);
        bus.w_resp_valid = 1'b1;
        sampleNeg();
        checkOutput("full_resp_cycle_hld", 64'(bus.hld), 64'd1);
        toPos();
        bus.w_resp_valid = 1'b0;
        checkOutput("full_wcnt_3", 64'(dut.wcnt), 64'd3);
        pushW(32'h310, 32'hB4, 1'b1);
        sampleNeg();
        checkOutput("release_hld", 64'(bus.hld), 64'd0);
        checkOutput("release_w_dv", 64'(bus.w_dv), 64'd1);
        toPos();
        idleInputs();
        checkOutput("release_wcnt_4", 64'(dut.wcnt), 64'd4);
        bus.w_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sampleNeg();
            toPos();
        end
        idleInputs();
        checkOutput("drain_wcnt_1", 64'(dut.wcnt), 64'd1);

        // Read start while one write is outstanding.
        applyStimulus(1'b0, 32'h400, 32'h0, 1'b1);
        pushR(32'h400, 1'b1);
`ifdef AXI_MGR_SPLIT_RAW_ORDER_EN
        sampleNeg();
        checkOutput("raw_hld", 64'(bus.hld), 64'd1);
        checkOutput("raw_r_dv", 64'(bus.r_dv), 64'd0);
        toPos();
        bus.w_resp_valid = 1'b1;
        sampleNeg();
        checkOutput("raw_resp_cycle_hld", 64'(bus.hld), 64'd1);
        toPos();
        bus.w_resp_valid = 1'b0;
        checkOutput("raw_wcnt_0", 64'(dut.wcnt), 64'd0);
        sampleNeg();
        checkOutput("raw_release_r_dv", 64'(bus.r_dv), 64'd1);
        checkOutput("raw_release_hld", 64'(bus.hld), 64'd0);
        toPos();
        idleInputs();
`else
        sampleNeg();
        checkOutput("noraw_r_dv", 64'(bus.r_dv), 64'd1);
        checkOutput("noraw_hld", 64'(bus.hld), 64'd0);
        toPos();
        idleInputs();
        bus.w_resp_valid = 1'b1;
        sampleNeg();
        toPos();
        idleInputs();
        checkOutput("noraw_wcnt_0", 64'(dut.wcnt), 64'd0);
`endif

        // Wrong-direction beat mid write burst, then asynchronous reset.
        applyStimulus(1'b1, 32'h500, 32'hC0, 1'b0);
        pushW(32'h500, 32'hC0, 1'b0);
        sampleNeg();
        toPos();
        checkOutput("mm_state_burst", 64'(dut.state_q), 64'(WR_BURST));
        checkOutput("mm_wcnt_1", 64'(dut.wcnt), 64'd1);
        applyStimulus(1'b0, 32'h504, 32'h0, 1'b1);
        sampleNeg();
        checkOutput("mm_hld", 64'(bus.hld), 64'd1);
        checkOutput("mm_r_dv", 64'(bus.r_dv), 64'd0);
        checkOutput("mm_w_dv", 64'(bus.w_dv), 64'd0);
        toPos();
        checkOutput("mm_state_held", 64'(dut.state_q), 64'(WR_BURST));
        rst_n = 1'b0;
        #1;
        checkOutput("arst_state", 64'(dut.state_q), 64'(IDLE));
        checkOutput("arst_wcnt", 64'(dut.wcnt), 64'd0);
        checkOutput("arst_r_dv", 64'(bus.r_dv), 64'd0);
        idleInputs();
        toPos();
        rst_n = 1'b1;
        toPos();
        checkOutput("post_rst_state", 64'(dut.state_q), 64'(IDLE));
        checkOutput("post_rst_wcnt", 64'(dut.wcnt), 64'd0);

        checkOutput("w_sb_drained", 64'(w_exp.size()), 64'd0);
        checkOutput("r_sb_drained", 64'(r_exp.size()), 64'd0);
        checkOutput("rdata_sb_drained", 64'(rdata_exp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
